// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and width helpers for the APB round-robin arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_t;

    // Index width for n requesters; at least one bit so n==1 stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width for a given TIMEOUT; at least one bit so TIMEOUT==0 stays legal.
    function automatic int to_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, with wrap.
module rr_pick
    import apb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int best_d;
    int d;

    // Choose the asserted request with the smallest rotational distance past ptr.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        best_d = N;
        d      = 0;
        for (int i = 0; i < N; i++) begin
            d = (i - int'(ptr) - 1 + 2 * N) % N;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                any    = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with a PREADY watchdog that force-completes hung transfers with an error.
//
// Handshake: a requester raises req_valid with stable fields and holds it until
// it sees its one-cycle req_done bit; the fields are captured at grant, so they
// may change freely afterwards. resp_rdata/resp_err are meaningful only in the
// req_done cycle. The requester may drop or replace its request in the cycle
// after req_done.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            resp_err,
    output logic                            timeout_evt,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic                            pwrite,
    output logic [DATA_WIDTH-1:0]           pwdata,
    output logic [DATA_WIDTH/8-1:0]         pstrb,
    output logic                            psel,
    output logic                            penable,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr,
    output apb_arb_state_t                  dbg_state
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int TO_W   = to_width(TIMEOUT);
    localparam bit WD_EN  = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] CNT_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

    apb_arb_state_t state, next_state;

    // ptr doubles as the grant index: it is updated to the winner at grant time.
    logic [IDX_W-1:0]      ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [TO_W-1:0]       cnt_q;

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_W-1:0]     sel_strb;
    logic                  done;
    logic                  to_fire;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Select the winning requester's fields out of the flattened buses.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    // FSM state register; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, APB phase strobes and completion decode.
    always_comb begin
        next_state = state;
        psel       = 1'b0;
        penable    = 1'b0;
        done       = 1'b0;
        to_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) next_state = SETUP;
            end
            SETUP: begin
                psel       = 1'b1;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    done = 1'b1;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    done    = 1'b1;
                    to_fire = 1'b1;
                end
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the winner's request at grant; fields hold through IDLE afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if ((state == IDLE) && pick_any) begin
            ptr_q   <= pick_idx;
            addr_q  <= sel_addr;
            wr_q    <= sel_write;
            wdata_q <= sel_wdata;
            strb_q  <= sel_write ? sel_strb : '0;
        end
    end

    // Watchdog: counts ACCESS cycles without pready, cleared outside ACCESS.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if ((state == ACCESS) && !done) begin
            cnt_q <= cnt_q + TO_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Response and APB output decode; pready has priority over the watchdog.
    always_comb begin
        req_done = '0;
        if (done) req_done[ptr_q] = 1'b1;
        resp_rdata  = done ? prdata : '0;
        resp_err    = done && ((pready && pslverr) || to_fire);
        timeout_evt = to_fire;
        paddr       = addr_q;
        pwdata      = wdata_q;
        pstrb       = strb_q;
        pwrite      = (state != IDLE) && wr_q;
        dbg_state   = state;
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter (NUM_REQ=4, TIMEOUT=16): directed
// scenarios followed by randomized traffic against a transfer-level model.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            timeout_evt;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic            psel;
  logic            penable;
  logic [DW-1:0]   prdata = '0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;
  apb_arb_state_t  dbg_state;

  apb_rr_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_done(req_done), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .timeout_evt(timeout_evt),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- requester table ----------------
  logic          t_v[N];
  logic [AW-1:0] t_addr[N];
  logic          t_wr[N];
  logic [DW-1:0] t_wdata[N];
  logic [SW-1:0] t_strb[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = t_v[i];
      req_write[i]            = t_wr[i];
      req_addr[i*AW +: AW]    = t_addr[i];
      req_wdata[i*DW +: DW]   = t_wdata[i];
      req_strb[i*SW +: SW]    = t_strb[i];
    end
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  int m_ptr      = N - 1;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan requesters in rotation order after the last winner.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (t_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_valid();
    for (int i = 0; i < N; i++) if (t_v[i]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post(input int i, input logic [AW-1:0] a, input logic wr,
                      input logic [DW-1:0] wd, input logic [SW-1:0] s);
    t_v[i] = 1'b1; t_addr[i] = a; t_wr[i] = wr; t_wdata[i] = wd; t_strb[i] = s;
  endtask

  task automatic post_random(input int i);
    post(i, $urandom, 1'(($urandom_range(0, 1))), $urandom, SW'($urandom_range(0, 15)));
  endtask

  // Runs one complete transfer starting in an IDLE cycle (called just after a negedge).
  // wait_cyc: ACCESS cycles before pready rises (>= TO means the slave hangs).
  // next_mode: 0 keep request, 1 drop it, 2 replace it with a new random one.
  task automatic run_xfer(input int wait_cyc, input bit slverr, input logic [DW-1:0] rdv,
                          input int next_mode);
    int w;
    bit rdy, to, fin;
    logic [N-1:0]  oh;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ewd;
    logic [SW-1:0] es;
    w = model_pick();
    if (w < 0) begin
      compared++; mismatched++;
      $error("FAIL no_request: observed none expected a pending requester");
      return;
    end
    ea = t_addr[w]; ew = t_wr[w]; ewd = t_wdata[w]; es = ew ? t_strb[w] : '0;
    oh = '0; oh[w] = 1'b1;
    exp_q.push_back(oh);

    @(negedge clk); #1;
    check("setup_state", dbg_state, SETUP);
    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, ea);
    check("setup_pwrite", pwrite, ew);
    check("setup_pwdata", pwdata, ewd);
    check("setup_pstrb", pstrb, es);
    check("setup_done", req_done, '0);

    fin = 1'b0;
    for (int c = 0; c < TO + 4 && !fin; c++) begin
      @(negedge clk);
      rdy = (c >= wait_cyc);
      pready = rdy; pslverr = slverr && rdy; prdata = rdv;
      #1;
      to  = !rdy && (c == TO - 1);
      fin = rdy || to;
      check("access_psel", psel, 1'b1);
      check("access_penable", penable, 1'b1);
      check("timeout_evt", timeout_evt, to);
      if (fin) begin
        check("req_done", req_done, exp_q.pop_front());
        check("resp_rdata", resp_rdata, rdv);
        check("resp_err", resp_err, rdy ? slverr : 1'b1);
      end else begin
        check("req_done_wait", req_done, '0);
      end
    end
    if (!fin) begin
      compared++; mismatched++;
      $error("FAIL done_bound: observed no completion expected one within %0d cycles", TO);
    end

    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0;
    m_ptr = w;
    if (next_mode == 1) t_v[w] = 1'b0;
    else if (next_mode == 2) post_random(w);
    #1;
    check("idle_state", dbg_state, IDLE);
    check("idle_psel", psel, 1'b0);
    check("idle_penable", penable, 1'b0);
    check("idle_pwrite", pwrite, 1'b0);
    check("idle_done", req_done, '0);
    check("idle_paddr_hold", paddr, ea);
    check("idle_pstrb_hold", pstrb, es);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, wc;
    for (int i = 0; i < N; i++) begin
      t_v[i] = 1'b0; t_addr[i] = '0; t_wr[i] = 1'b0; t_wdata[i] = '0; t_strb[i] = '0;
    end

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, '0);
    check("rst_pwdata", pwdata, '0);
    check("rst_pstrb", pstrb, '0);
    check("rst_done", req_done, '0);
    check("rst_tevt", timeout_evt, 1'b0);
    rst = 1'b1;

    // No request: stays idle
    @(negedge clk); #1;
    check("noreq_state", dbg_state, IDLE);
    check("noreq_psel", psel, 1'b0);

    // Single read from requester 0
    post(0, 32'h40, 1'b0, 32'h0, 4'hF);
    run_xfer(0, 1'b0, 32'hDEADBEEF, 1);

    // Two requesters holding writes: grants alternate
    post(0, 32'h10, 1'b1, 32'h1111_0000, 4'h3);
    post(1, 32'h20, 1'b1, 32'h2222_0000, 4'hC);
    run_xfer(0, 1'b0, $urandom, 0);
    run_xfer(0, 1'b0, $urandom, 0);
    run_xfer(0, 1'b0, $urandom, 0);
    run_xfer(0, 1'b0, $urandom, 1);
    run_xfer(0, 1'b0, $urandom, 1);

    // Hung slave: watchdog completes in the 16th ACCESS cycle, then a normal transfer
    post(0, 32'h80, 1'b0, 32'h0, 4'h0);
    run_xfer(100, 1'b0, $urandom, 2);
    run_xfer(0, 1'b0, $urandom, 1);

    // pready with pslverr on the last watchdog cycle: pready wins
    post(1, 32'h90, 1'b1, 32'h5A5A_5A5A, 4'h9);
    run_xfer(TO - 1, 1'b1, $urandom, 1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) if (!t_v[i] && ($urandom_range(0, 1) == 1)) post_random(i);
      if (!any_valid()) post_random($urandom_range(0, N - 1));
      r  = $urandom_range(0, 9);
      wc = (r == 0) ? 100 : (r == 1) ? TO - 1 : (r < 5) ? $urandom_range(1, 3) : 0;
      run_xfer(wc, ($urandom_range(0, 3) == 0), $urandom, $urandom_range(1, 2));
    end
    for (int k = 0; k < N; k++) if (any_valid()) run_xfer(0, 1'b0, $urandom, 1);

    // Reset during ACCESS aborts the transfer
    post(2, 32'hA0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    #1;
    check("abort_in_access", dbg_state, ACCESS);
    rst = 1'b0;
    @(negedge clk); #1;
    check("abort_psel", psel, 1'b0);
    check("abort_penable", penable, 1'b0);
    check("abort_done", req_done, '0);
    rst = 1'b1;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) post_random(i);
    run_xfer(0, 1'b0, $urandom, 1);
    for (int k = 0; k < N; k++) if (any_valid()) run_xfer(0, 1'b0, $urandom, 1);

    // Requesters 1 and 3 only, pointer at 1: 3 then 1, 0 and 2 never served
    post(1, 32'hB0, 1'b0, 32'h0, 4'h0);
    run_xfer(0, 1'b0, $urandom, 0);
    post(3, 32'hC0, 1'b1, 32'h3333_3333, 4'h6);
    run_xfer(0, 1'b0, $urandom, 0);
    run_xfer(0, 1'b0, $urandom, 0);
    run_xfer(0, 1'b0, $urandom, 1);
    run_xfer(0, 1'b0, $urandom, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed simulation still running expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
